// File: rtl/frame_sequencer_if.sv
// Handshake and display-memory bundle between the frame sequencer and the game blocks.
// The master side is the sequencer. The slave side is the player/object blocks plus the frame timer.
interface frame_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              frame_tick;
    logic              go_plyr;
    logic              plyr_we;
    logic [ADDR_W-1:0] plyr_addr;
    logic [DATA_W-1:0] plyr_data;
    logic              done_plyr;
    logic              go_obj;
    logic              obj_we;
    logic [ADDR_W-1:0] obj_addr;
    logic [DATA_W-1:0] obj_data;
    logic              done_obj;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    modport master (
        input  frame_tick,
        input  plyr_we, plyr_addr, plyr_data, done_plyr,
        input  obj_we, obj_addr, obj_data, done_obj,
        output go_plyr, go_obj,
        output mem_we, mem_addr, mem_data,
        output busy, overrun, timeout_err
    );

    modport slave (
        output frame_tick,
        output plyr_we, plyr_addr, plyr_data, done_plyr,
        output obj_we, obj_addr, obj_data, done_obj,
        input  go_plyr, go_obj,
        input  mem_we, mem_addr, mem_data,
        input  busy, overrun, timeout_err
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame scheduler for the 8x8 LED catch game.
// Each frame optionally clears display memory, then hands the single write port
// to player control and then to the falling-object block, one owner at a time.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  S_IDLE     | waiting for frame_tick or a pending tick
//  S_CLEAR    | writing 0 to every cell, ascending, one cell per cycle
//  S_PLYR_GO  | go_plyr pulse; player writes are not yet accepted
//  S_PLYR     | player owns the write port until done_plyr or timeout
//  S_OBJ_GO   | go_obj pulse; object writes are not yet accepted
//  S_OBJ      | object block owns the write port until done_obj or timeout
module frame_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 255,
    parameter bit CLEAR_EN = 1'b1
) (
    input logic               clock,
    input logic               reset,
    frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLYR_GO,
        S_PLYR,
        S_OBJ_GO,
        S_OBJ
    } state_t;

    state_t            state;
    logic              pending;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        ph_cnt;
    logic              ph_last;

    // The cycle in which a phase gives up waiting for done.
    assign ph_last = (ph_cnt == 8'(TIMEOUT - 1));

    // Sequencer FSM, write-port mux, tick bookkeeping and sticky flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            pending         <= 1'b0;
            clr_cnt         <= '0;
            ph_cnt          <= '0;
            bus.go_plyr     <= 1'b0;
            bus.go_obj      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data    <= '0;
            bus.busy        <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.go_plyr  <= 1'b0;
            bus.go_obj   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;

            // At most one tick is remembered while a frame is running.
            if (state != S_IDLE && bus.frame_tick) begin
                if (pending)
                    bus.overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.frame_tick || pending) begin
                        if (bus.frame_tick && pending)
                            bus.overrun <= 1'b1;
                        pending  <= 1'b0;
                        bus.busy <= 1'b1;
                        if (CLEAR_EN) begin
                            // Issue cell 0 straight away so CLEAR shows one cell per cycle.
                            state      <= S_CLEAR;
                            bus.mem_we <= 1'b1;
                            clr_cnt    <= clr_cnt + 1'b1;
                        end else begin
                            state       <= S_PLYR_GO;
                            bus.go_plyr <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    // clr_cnt has wrapped to 0 once the last cell went out.
                    if (clr_cnt == '0) begin
                        state       <= S_PLYR_GO;
                        bus.go_plyr <= 1'b1;
                    end else begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= clr_cnt;
                        clr_cnt      <= clr_cnt + 1'b1;
                    end
                end

                S_PLYR_GO: begin
                    state  <= S_PLYR;
                    ph_cnt <= '0;
                end

                S_PLYR: begin
                    ph_cnt <= ph_cnt + 8'd1;
                    if (bus.plyr_we && (bus.done_plyr || !ph_last)) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= bus.plyr_addr;
                        bus.mem_data <= bus.plyr_data;
                    end
                    if (bus.done_plyr || ph_last) begin
                        state      <= S_OBJ_GO;
                        bus.go_obj <= 1'b1;
                        if (!bus.done_plyr)
                            bus.timeout_err <= 1'b1;
                    end
                end

                S_OBJ_GO: begin
                    state  <= S_OBJ;
                    ph_cnt <= '0;
                end

                S_OBJ: begin
                    ph_cnt <= ph_cnt + 8'd1;
                    if (bus.obj_we && (bus.done_obj || !ph_last)) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= bus.obj_addr;
                        bus.mem_data <= bus.obj_data;
                    end
                    if (bus.done_obj || ph_last) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                        if (!bus.done_obj)
                            bus.timeout_err <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
